// File: rtl/cmul_share_arbiter.sv
// Round-robin arbiter that time-shares one sequenced complex-multiplier core
// among NREQ requesters, with a bounded wait on the core's done strobe.
module cmul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int RW      = 33,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_ar,
    input  logic [NREQ*W-1:0]        req_ai,
    input  logic [NREQ*W-1:0]        req_br,
    input  logic [NREQ*W-1:0]        req_bi,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [RW-1:0]            rsp_pr,
    output logic [RW-1:0]            rsp_pi,
    output logic                     rsp_err,
    output logic                     core_start,
    output logic [W-1:0]             core_ar,
    output logic [W-1:0]             core_ai,
    output logic [W-1:0]             core_br,
    output logic [W-1:0]             core_bi,
    input  logic                     core_done,
    input  logic [RW-1:0]            core_pr,
    input  logic [RW-1:0]            core_pi,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int          GW   = $clog2(NREQ);
    localparam int          TW   = $clog2(TIMEOUT);
    localparam int unsigned NR   = NREQ;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [W-1:0]    ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic [RW-1:0]   pr_q, pr_d, pi_q, pi_d;
    logic            err_q, err_d;

    logic [W-1:0]    ar_s [NREQ];
    logic [W-1:0]    ai_s [NREQ];
    logic [W-1:0]    br_s [NREQ];
    logic [W-1:0]    bi_s [NREQ];
    logic            found;
    logic [GW-1:0]   win;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign ar_s[g] = req_ar[g*W +: W];
        assign ai_s[g] = req_ai[g*W +: W];
        assign br_s[g] = req_br[g*W +: W];
        assign bi_s[g] = req_bi[g*W +: W];
    end

    // Search starts just after the last granted requester and wraps modulo NREQ.
    always_comb begin
        int unsigned idx;
        logic [GW-1:0] idx_g;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = k + 32'(last_q);
            if (idx >= NR) begin
                idx = idx - NR;
            end
            idx_g = GW'(idx);
            if (!found && req_valid[idx_g]) begin
                found = 1'b1;
                win   = idx_g;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_d     = last_q;
        grant_d    = grant_q;
        ar_d       = ar_q;
        ai_d       = ai_q;
        br_d       = br_q;
        bi_d       = bi_q;
        pr_d       = pr_q;
        pi_d       = pi_q;
        err_d      = err_q;
        req_ready  = '0;
        rsp_valid  = '0;
        core_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    // Ready is combinational, so hold it low while reset is asserted.
                    req_ready[win] = ~rst;
                    ar_d    = ar_s[win];
                    ai_d    = ai_s[win];
                    br_d    = br_s[win];
                    bi_d    = bi_s[win];
                    grant_d = win;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_start = 1'b1;
                timer_d    = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    pr_d    = core_pr;
                    pi_d    = core_pi;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == TMAX) begin
                    pr_d    = '0;
                    pi_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                last_d             = grant_q;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            last_q  <= GW'(NREQ - 1);
            grant_q <= '0;
            ar_q    <= '0;
            ai_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            pr_q    <= '0;
            pi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            pr_q    <= pr_d;
            pi_q    <= pi_d;
            err_q   <= err_d;
        end
    end

    assign core_ar  = ar_q;
    assign core_ai  = ai_q;
    assign core_br  = br_q;
    assign core_bi  = bi_q;
    assign rsp_pr   = pr_q;
    assign rsp_pi   = pi_q;
    assign rsp_err  = err_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmul_share_arbiter.sv
// Directed bench for cmul_share_arbiter: a job table on a 4-requester instance
// plus hand sequences for reset, stray done and a 3-requester instance.
module tb_cmul_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 4-requester instance
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready, rsp_valid;
    logic [63:0] req_ar = '0, req_ai = '0, req_br = '0, req_bi = '0;
    logic [32:0] rsp_pr, rsp_pi;
    logic        rsp_err, core_start, busy;
    logic [15:0] core_ar, core_ai, core_br, core_bi;
    logic        core_done;
    logic [32:0] core_pr = '0, core_pi = '0;
    logic [1:0]  grant_id;

    // core model state
    int          delay_m = 0;
    int          cnt_m = 0;
    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;
    logic [32:0] pr_m = '0, pi_m = '0;
    assign core_done = model_done | stray_done;

    cmul_share_arbiter #(.NREQ(4), .W(16), .RW(33), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ar(req_ar), .req_ai(req_ai), .req_br(req_br), .req_bi(req_bi),
        .rsp_valid(rsp_valid), .rsp_pr(rsp_pr), .rsp_pi(rsp_pi), .rsp_err(rsp_err),
        .core_start(core_start),
        .core_ar(core_ar), .core_ai(core_ai), .core_br(core_br), .core_bi(core_bi),
        .core_done(core_done), .core_pr(core_pr), .core_pi(core_pi),
        .busy(busy), .grant_id(grant_id)
    );

    // 3-requester instance
    logic [2:0]  req_valid3 = '0;
    logic [2:0]  req_ready3, rsp_valid3;
    logic [47:0] req_op3 = '0;
    logic [32:0] rsp_pr3, rsp_pi3;
    logic        rsp_err3, core_start3, busy3;
    logic [15:0] core_ar3, core_ai3, core_br3, core_bi3;
    logic        done3 = 1'b0;
    logic [32:0] core_r3 = '0;
    logic [1:0]  grant3;

    cmul_share_arbiter #(.NREQ(3), .W(16), .RW(33), .TIMEOUT(15)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_ar(req_op3), .req_ai(req_op3), .req_br(req_op3), .req_bi(req_op3),
        .rsp_valid(rsp_valid3), .rsp_pr(rsp_pr3), .rsp_pi(rsp_pi3), .rsp_err(rsp_err3),
        .core_start(core_start3),
        .core_ar(core_ar3), .core_ai(core_ai3), .core_br(core_br3), .core_bi(core_bi3),
        .core_done(done3), .core_pr(core_r3), .core_pi(core_r3),
        .busy(busy3), .grant_id(grant3)
    );

    // Core model: done pulses delay_m cycles after the start cycle; 0 means never.
    initial forever begin
        @(negedge clk);
        model_done = 1'b0;
        if (cnt_m > 0) begin
            cnt_m--;
            if (cnt_m == 0) begin
                model_done = 1'b1;
                core_pr    = pr_m;
                core_pi    = pi_m;
            end
        end
        if (core_start === 1'b1 && delay_m > 0) cnt_m = delay_m;
    end

    typedef struct {
        logic        rst_before;
        logic [3:0]  valid;
        int          grant;
        logic [15:0] ar, ai, br, bi;
        int          delay;
        logic [32:0] pr, pi;
        logic        stray;
        int          lat;
        logic        err;
        logic [32:0] epr, epi;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_job(input vec_t v, input int row);
        logic [3:0] oh;
        int n;
        oh = 4'(1 << v.grant);
        if (v.rst_before) begin
            rst = 1'b1;
            req_valid = '0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
        end
        delay_m = v.delay;
        pr_m    = v.pr;
        pi_m    = v.pi;
        req_ar[v.grant*16 +: 16] = v.ar;
        req_ai[v.grant*16 +: 16] = v.ai;
        req_br[v.grant*16 +: 16] = v.br;
        req_bi[v.grant*16 +: 16] = v.bi;
        req_valid = v.valid;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("r%0d ready", row), 64'(req_ready), 64'(oh));
        @(negedge clk);
        if (v.valid != 4'hF) req_valid = '0;
        stray_done = v.stray;
        #1;
        chk($sformatf("r%0d start/busy", row), 64'({core_start, busy}), 64'(2'b11));
        chk($sformatf("r%0d grant_id", row), 64'(grant_id), 64'(v.grant));
        chk($sformatf("r%0d core ops", row), {core_ar, core_ai, core_br, core_bi},
            {v.ar, v.ai, v.br, v.bi});
        n = 0;
        do begin
            @(negedge clk);
            stray_done = 1'b0;
            #1;
            n++;
        end while (rsp_valid == 4'b0 && n < 40);
        chk($sformatf("r%0d rsp_valid", row), 64'(rsp_valid), 64'(oh));
        chk($sformatf("r%0d latency", row), 64'(n), 64'(v.lat));
        chk($sformatf("r%0d rsp_pr", row), 64'(rsp_pr), 64'(v.epr));
        chk($sformatf("r%0d rsp_pi", row), 64'(rsp_pi), 64'(v.epi));
        chk($sformatf("r%0d rsp_err", row), 64'(rsp_err), 64'(v.err));
        @(negedge clk);
        #1;
        chk($sformatf("r%0d idle after", row), 64'({busy, rsp_valid, core_start}), 64'(0));
    endtask

    task automatic run3(input logic [2:0] vm, input logic [2:0] exp, input int expg,
                        input logic [2:0] after);
        int n;
        req_valid3 = vm;
        #1;
        n = 0;
        while (req_ready3 == 3'b0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("u3 ready", 64'(req_ready3), 64'(exp));
        @(negedge clk);
        req_valid3 = after;
        #1;
        chk("u3 grant_id", 64'(grant3), 64'(expg));
        @(negedge clk);
        done3 = 1'b1;
        @(negedge clk);
        done3 = 1'b0;
        #1;
        chk("u3 rsp_valid", 64'(rsp_valid3), 64'(exp));
        @(negedge clk);
        #1;
    endtask

    vec_t tbl[10];

    initial begin
        int n;
        tbl[0] = '{1'b1, 4'hF, 0, 16'd11, 16'd12, 16'd13, 16'd14, 3, 33'd100, -33'sd100,
                   1'b0, 4, 1'b0, 33'd100, -33'sd100};
        tbl[1] = '{1'b0, 4'hF, 1, 16'd21, 16'd22, 16'd23, 16'd24, 1, 33'd5, 33'd6,
                   1'b0, 2, 1'b0, 33'd5, 33'd6};
        tbl[2] = '{1'b0, 4'hF, 2, 16'd31, -16'sd32, 16'd33, 16'd34, 2, -33'sd1, 33'd2,
                   1'b0, 3, 1'b0, -33'sd1, 33'd2};
        tbl[3] = '{1'b0, 4'hF, 3, 16'd41, 16'd42, 16'd43, 16'd44, 4, 33'd7, 33'd8,
                   1'b0, 5, 1'b0, 33'd7, 33'd8};
        tbl[4] = '{1'b0, 4'hF, 0, 16'd51, 16'd52, 16'd53, 16'd54, 3, 33'd9, 33'd10,
                   1'b0, 4, 1'b0, 33'd9, 33'd10};
        tbl[5] = '{1'b0, 4'hF, 1, 16'd61, 16'd62, 16'd63, 16'd64, 2, 33'd11, 33'd12,
                   1'b0, 3, 1'b0, 33'd11, 33'd12};
        tbl[6] = '{1'b1, 4'b0100, 2, 16'd3, 16'd4, 16'd5, -16'sd2, 5, 33'd23, 33'd14,
                   1'b0, 6, 1'b0, 33'd23, 33'd14};
        tbl[7] = '{1'b0, 4'b0010, 1, 16'd1, 16'd1, 16'd1, 16'd1, 0, 33'd55, 33'd66,
                   1'b0, 16, 1'b1, 33'd0, 33'd0};
        tbl[8] = '{1'b0, 4'b0001, 0, 16'd2, 16'd2, 16'd2, 16'd2, 15, -33'sd7, 33'd9,
                   1'b0, 16, 1'b0, -33'sd7, 33'd9};
        tbl[9] = '{1'b0, 4'b0001, 0, 16'd5, 16'd6, 16'd7, 16'd8, 3, 33'd40, 33'd41,
                   1'b1, 4, 1'b0, 33'd40, 33'd41};

        // reset values
        #1 rst = 1'b1;
        #1;
        chk("reset ctl", 64'({req_ready, rsp_valid, rsp_err, core_start, busy, grant_id}), 64'(0));
        chk("reset core ops", {core_ar, core_ai, core_br, core_bi}, 64'(0));
        chk("reset rsp data", 64'(rsp_pr | rsp_pi), 64'(0));
        req_valid = 4'hF;
        #1;
        chk("ready in reset", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) do_job(tbl[i], i);

        // stray done in IDLE: no state change, results held
        req_valid = '0;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        #1;
        chk("stray idle", 64'({busy, rsp_valid}), 64'(0));
        @(negedge clk);
        #1;
        chk("stray idle 2", 64'({busy, rsp_valid}), 64'(0));
        chk("rsp hold", 64'({rsp_err, rsp_pr}), 64'({1'b0, 33'd40}));

        // reset during WAIT of a job for requester 3
        delay_m = 0;
        req_valid = 4'b1000;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("r3 ready", 64'(req_ready), 64'(4'b1000));
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1010;
        delay_m = 2;
        #1;
        chk("mid rst ctl", 64'({req_ready, rsp_valid, rsp_err, core_start, busy, grant_id}), 64'(0));
        chk("mid rst core ops", {core_ar, core_ai, core_br, core_bi}, 64'(0));
        chk("mid rst rsp data", 64'(rsp_pr | rsp_pi), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post rst ready", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        req_valid = 4'b1000;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (rsp_valid == 4'b0 && n < 40);
        chk("post rst rsp", 64'(rsp_valid), 64'(4'b0010));
        @(negedge clk);
        #1;
        chk("next ready", 64'(req_ready), 64'(4'b1000));
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("dropped req", 64'(busy), 64'(0));

        // 3-requester wrap order
        run3(3'b010, 3'b010, 1, 3'b000);
        run3(3'b101, 3'b100, 2, 3'b001);
        run3(3'b001, 3'b001, 0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
